// File: rtl/time_display_driver.sv
// Converts the stopwatch binary time fields to BCD with a sequential double-dabble
// engine and scans them onto a six-digit multiplexed 7-segment display (HH.MM.SS).
module time_display_driver #(
  parameter int unsigned CLOCK_FREQ     = 32'd50_000_000,
  parameter int unsigned SCAN_HZ        = 32'd1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_minutes,
  input  logic [4:0] i_hours,
  input  logic       i_paused,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [5:0] o_an,
  output logic       o_busy
);

  localparam int unsigned SCAN_DIV  = CLOCK_FREQ / SCAN_HZ;
  localparam int unsigned BLINK_DIV = CLOCK_FREQ / 2;
  localparam int unsigned CNT_W     = 32;
  localparam logic [6:0]  POL7      = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0]  POL6      = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;
  localparam logic        POL1      = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t           state;
  logic [5:0]       snap_s, snap_m;
  logic [4:0]       snap_h;
  logic [7:0]       scratch;
  logic [23:0]      hold;
  logic [23:0]      digits;
  logic [1:0]       fld;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_ph;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Double-dabble step: adjust nibbles, then shift in the current field bit (MSB first)
  logic [5:0] cur_field;
  logic       cur_bit;
  logic [3:0] adj_hi, adj_lo;
  logic [7:0] dabble_nxt;

  always_comb begin
    cur_field = snap_s;
    case (fld)
      2'd1:    cur_field = snap_m;
      2'd2:    cur_field = {1'b0, snap_h};
      default: cur_field = snap_s;
    endcase
    cur_bit    = cur_field[3'd5 - bit_idx];
    adj_hi     = (scratch[7:4] >= 4'd5) ? scratch[7:4] + 4'd3 : scratch[7:4];
    adj_lo     = (scratch[3:0] >= 4'd5) ? scratch[3:0] + 4'd3 : scratch[3:0];
    dabble_nxt = {adj_hi[2:0], adj_lo, cur_bit};
  end

  // Scan pipeline: outputs are registered from the next index so they move with it
  logic        scan_tc;
  logic [2:0]  idx_nxt;
  logic [23:0] disp_src;
  logic [3:0]  cur_digit;
  logic        dp_lit;
  logic        changed;

  always_comb begin
    scan_tc   = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    idx_nxt   = scan_idx;
    if (scan_tc) idx_nxt = (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    disp_src  = (state == S_COMMIT) ? hold : digits;
    cur_digit = disp_src[3:0];
    case (idx_nxt)
      3'd1:    cur_digit = disp_src[7:4];
      3'd2:    cur_digit = disp_src[11:8];
      3'd3:    cur_digit = disp_src[15:12];
      3'd4:    cur_digit = disp_src[19:16];
      3'd5:    cur_digit = disp_src[23:20];
      default: cur_digit = disp_src[3:0];
    endcase
    dp_lit  = ((idx_nxt == 3'd2) || (idx_nxt == 3'd4)) && (!i_paused || blink_ph);
    changed = {i_hours, i_minutes, i_seconds} != {snap_h, snap_m, snap_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      snap_s    <= '0;
      snap_m    <= '0;
      snap_h    <= '0;
      scratch   <= '0;
      hold      <= '0;
      digits    <= '0;
      fld       <= '0;
      bit_idx   <= '0;
      scan_cnt  <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b1;
      o_seg     <= POL7 ^ 7'h3F;
      o_an      <= POL6 ^ 6'b000001;
      o_dp      <= POL1;
      o_busy    <= 1'b0;
    end else begin
      scan_cnt <= scan_tc ? '0 : scan_cnt + CNT_W'(1);
      scan_idx <= idx_nxt;
      o_an     <= POL6 ^ (6'b000001 << idx_nxt);
      o_seg    <= POL7 ^ seg7(cur_digit);
      o_dp     <= POL1 ^ dp_lit;

      // Blink phase only runs while paused; otherwise parked at "lit"
      if (!i_paused) begin
        blink_cnt <= '0;
        blink_ph  <= 1'b1;
      end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (changed) begin
            snap_s  <= i_seconds;
            snap_m  <= i_minutes;
            snap_h  <= i_hours;
            scratch <= '0;
            fld     <= '0;
            bit_idx <= '0;
            o_busy  <= 1'b1;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_idx == 3'd5) begin
            case (fld)
              2'd0:    hold[7:0]   <= dabble_nxt;
              2'd1:    hold[15:8]  <= dabble_nxt;
              default: hold[23:16] <= dabble_nxt;
            endcase
            scratch <= '0;
            bit_idx <= '0;
            if (fld == 2'd2) begin
              fld   <= '0;
              state <= S_COMMIT;
            end else begin
              fld <= fld + 2'd1;
            end
          end else begin
            scratch <= dabble_nxt;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_COMMIT: begin
          digits <= hold;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
